// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - receive-side VGA sync decoder
// Recovers pixel/line counters from active-low syncs, measures timing and tracks lock.
module vga_sync_decoder #(
   parameter int CW    = 10,
   parameter int MIN_X = 64,
   parameter int MIN_Y = 16,
   parameter int ACT_W = 640,
   parameter int ACT_H = 480
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pixel_en,
   input  logic          vga_h_sync,
   input  logic          vga_v_sync,
   output logic [CW-1:0] CounterX,
   output logic [CW-1:0] CounterY,
   output logic          inDisplayArea,
   output logic [CW-1:0] line_len,
   output logic [CW-1:0] frame_lines,
   output logic          locked,
   output logic          sync_err
);
   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW:0]   ONE     = (CW+1)'(1);
   localparam logic [CW:0]   X_LO    = (CW+1)'(MIN_X);
   localparam logic [CW:0]   X_HI    = (CW+1)'(MIN_X + ACT_W - 1);
   localparam logic [CW:0]   Y_LO    = (CW+1)'(MIN_Y);
   localparam logic [CW:0]   Y_HI    = (CW+1)'(MIN_Y + ACT_H - 1);

   logic          hs_meta_q, hs_meta_d, hs_s_q, hs_s_d;
   logic          vs_meta_q, vs_meta_d, vs_s_q, vs_s_d;
   logic          hs_prev_q, hs_prev_d;
   logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
   logic [CW-1:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
   logic [CW:0]   ref_len_q, ref_len_d, ref_lines_q, ref_lines_d;
   logic          frame_ok_q, frame_ok_d;
   logic          locked_q, locked_d, sync_err_q, sync_err_d;
   state_t        state_q, state_d;

   logic          h_edge, frame_start, timeout;
   logic [CW:0]   x_inc, y_inc;
   logic [CW-1:0] x_next, y_next;

   always_comb begin
      hs_meta_d     = vga_h_sync;
      hs_s_d        = hs_meta_q;
      vs_meta_d     = vga_v_sync;
      vs_s_d        = vs_meta_q;
      hs_prev_d     = hs_prev_q;
      cx_d          = cx_q;
      cy_d          = cy_q;
      line_len_d    = line_len_q;
      frame_lines_d = frame_lines_q;
      state_d       = state_q;
      ref_len_d     = ref_len_q;
      ref_lines_d   = ref_lines_q;
      frame_ok_d    = frame_ok_q;

      h_edge      = pixel_en & hs_prev_q & ~hs_s_q;
      frame_start = h_edge & ~vs_s_q;
      timeout     = pixel_en & ~h_edge & (cx_q == CNT_MAX - 1'b1);
      // Increments are one bit wider so an all-ones count never wraps to 0
      x_inc  = {1'b0, cx_q} + ONE;
      y_inc  = {1'b0, cy_q} + ONE;
      x_next = x_inc[CW] ? CNT_MAX : x_inc[CW-1:0];
      y_next = y_inc[CW] ? CNT_MAX : y_inc[CW-1:0];

      if (pixel_en) begin
         hs_prev_d = hs_s_q;
         if (h_edge) begin
            line_len_d = x_next;
            cx_d       = '0;
            if (frame_start) begin
               frame_lines_d = y_next;
               cy_d          = '0;
            end else begin
               cy_d = y_next;
            end
         end else begin
            cx_d = x_next;
         end

         case (state_q)
            SEARCH: begin
               if (frame_start) begin
                  state_d    = ACQUIRE;
                  ref_len_d  = '0;
                  frame_ok_d = 1'b1;
               end
            end
            ACQUIRE: begin
               if (timeout) begin
                  state_d = SEARCH;
               end else if (frame_start) begin
                  if (frame_ok_q && (ref_len_q != '0) && (x_inc == ref_len_q)) begin
                     state_d     = LOCKED;
                     ref_lines_d = y_inc;
                  end else begin
                     ref_len_d  = '0;
                     frame_ok_d = 1'b1;
                  end
               end else if (h_edge) begin
                  if (ref_len_q == '0) begin
                     ref_len_d = x_inc;
                  end else if (x_inc != ref_len_q) begin
                     frame_ok_d = 1'b0;
                  end
               end
            end
            LOCKED: begin
               if (timeout || (h_edge && (x_inc != ref_len_q)) ||
                   (frame_start && (y_inc != ref_lines_q))) begin
                  state_d = SEARCH;
               end
            end
            default: state_d = SEARCH;
         endcase
      end

      // One pulse per loss of lock, however many causes coincide
      sync_err_d = (state_q != SEARCH) && (state_d == SEARCH);
      locked_d   = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_meta_q     <= 1'b1;
         hs_s_q        <= 1'b1;
         vs_meta_q     <= 1'b1;
         vs_s_q        <= 1'b1;
         hs_prev_q     <= 1'b1;
         cx_q          <= '0;
         cy_q          <= '0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         state_q       <= SEARCH;
         ref_len_q     <= '0;
         ref_lines_q   <= '0;
         frame_ok_q    <= 1'b0;
         locked_q      <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         hs_meta_q     <= hs_meta_d;
         hs_s_q        <= hs_s_d;
         vs_meta_q     <= vs_meta_d;
         vs_s_q        <= vs_s_d;
         hs_prev_q     <= hs_prev_d;
         cx_q          <= cx_d;
         cy_q          <= cy_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         state_q       <= state_d;
         ref_len_q     <= ref_len_d;
         ref_lines_q   <= ref_lines_d;
         frame_ok_q    <= frame_ok_d;
         locked_q      <= locked_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign CounterX      = cx_q;
   assign CounterY      = cy_q;
   assign line_len      = line_len_q;
   assign frame_lines   = frame_lines_q;
   assign locked        = locked_q;
   assign sync_err      = sync_err_q;
   assign inDisplayArea = locked_q &
                          ({1'b0, cx_q} >= X_LO) & ({1'b0, cx_q} <= X_HI) &
                          ({1'b0, cy_q} >= Y_LO) & ({1'b0, cy_q} <= Y_HI);
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - scoreboard bench for vga_sync_decoder
// Expected outputs come from a line/frame-level timing model; a monitor compares every clk.
module tb_vga_sync_decoder;
   localparam int CW    = 7;
   localparam int MIN_X = 8;
   localparam int MIN_Y = 4;
   localparam int ACT_W = 32;
   localparam int ACT_H = 16;
   localparam int MAXV  = (1 << CW) - 1;
   localparam int LINE  = 48;
   localparam int LINES = 24;
   localparam int HUNT = 0, COLLECT = 1, HOLD = 2;

   logic          clk = 1'b0;
   logic          rst, pixel_en, vga_h_sync, vga_v_sync;
   logic [CW-1:0] CounterX, CounterY, line_len, frame_lines;
   logic          inDisplayArea, locked, sync_err;

   always #5 clk = ~clk;

   vga_sync_decoder #(.CW(CW), .MIN_X(MIN_X), .MIN_Y(MIN_Y), .ACT_W(ACT_W), .ACT_H(ACT_H)) dut (
      .clk(clk), .rst(rst), .pixel_en(pixel_en), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
      .CounterX(CounterX), .CounterY(CounterY), .inDisplayArea(inDisplayArea),
      .line_len(line_len), .frame_lines(frame_lines), .locked(locked), .sync_err(sync_err)
   );

   typedef struct packed {
      logic [CW-1:0] x, y, len, lines;
      logic          ida, lck, err;
   } obs_t;
   typedef struct packed {
      logic hs_low;
      logic vs_low;
   } tick_t;

   tick_t tq[$];
   obs_t  eq[$];
   int    checks = 0;
   int    passes = 0;

   // Model state: ticks since last hsync, lines since frame start, lock bookkeeping
   int    m_t, m_k, m_mode, m_ref_len, m_ref_lines;
   int    m_lens[$];
   obs_t  m_obs;

   function automatic int sat(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   function automatic bit all_equal(input int q[$]);
      foreach (q[i]) if (q[i] != q[0]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void check_obs(input string name, input obs_t a, input obs_t e);
      checks++;
      if (a == e) passes++;
      else $display("FAIL %s t=%0t got x=%0d y=%0d len=%0d lines=%0d ida=%0b lck=%0b err=%0b want x=%0d y=%0d len=%0d lines=%0d ida=%0b lck=%0b err=%0b",
                    name, $time, a.x, a.y, a.len, a.lines, a.ida, a.lck, a.err,
                    e.x, e.y, e.len, e.lines, e.ida, e.lck, e.err);
   endfunction

   function automatic void check_val(input string name, input int got, input int want);
      checks++;
      if (got == want) passes++;
      else $display("FAIL %s got=%0d want=%0d", name, got, want);
   endfunction

   function automatic void model_reset();
      m_t = 0; m_k = 0; m_mode = HUNT; m_ref_len = 0; m_ref_lines = 0;
      m_lens.delete();
      m_obs = '0;
   endfunction

   function automatic void gen_tick(input bit hs_low, input bit vs_low);
      int meas, lmeas;
      bit fs;
      fs = hs_low && vs_low;
      m_obs.err = 1'b0;
      if (hs_low) begin
         meas  = sat(m_t, MAXV) + 1;
         lmeas = sat(m_k, MAXV) + 1;
         m_obs.len = CW'(sat(meas, MAXV));
         if (fs) m_obs.lines = CW'(sat(lmeas, MAXV));
         if (m_mode == HUNT) begin
            if (fs) begin m_mode = COLLECT; m_lens.delete(); end
         end else if (m_mode == COLLECT) begin
            m_lens.push_back(meas);
            if (fs) begin
               if (m_lens.size() >= 2 && all_equal(m_lens)) begin
                  m_mode = HOLD; m_ref_len = meas; m_ref_lines = lmeas;
               end
               m_lens.delete();
            end
         end else if (meas != m_ref_len || (fs && lmeas != m_ref_lines)) begin
            m_mode = HUNT; m_obs.err = 1'b1;
         end
         m_t = 0;
         m_k = fs ? 0 : m_k + 1;
      end else begin
         m_t++;
         if (m_t == MAXV && m_mode != HUNT) begin m_mode = HUNT; m_obs.err = 1'b1; end
      end
      m_obs.x   = CW'(sat(m_t, MAXV));
      m_obs.y   = CW'(sat(m_k, MAXV));
      m_obs.lck = (m_mode == HOLD);
      m_obs.ida = m_obs.lck && (sat(m_t, MAXV) >= MIN_X) && (sat(m_t, MAXV) <= MIN_X + ACT_W - 1) &&
                  (sat(m_k, MAXV) >= MIN_Y) && (sat(m_k, MAXV) <= MIN_Y + ACT_H - 1);
      tq.push_back({hs_low, vs_low});
      eq.push_back(m_obs);
   endfunction

   function automatic void gen_line(input int len, input bit fs);
      gen_tick(1'b1, fs);
      for (int i = 1; i < len; i++) gen_tick(1'b0, 1'b0);
   endfunction

   function automatic void gen_frame(input int len, input int nlines, input int short_idx);
      for (int i = 0; i < nlines; i++) gen_line((i == short_idx) ? len - 1 : len, i == 0);
   endfunction

   // Sync levels are driven two clocks ahead of the tick that must see them
   task automatic run_seg(input int maxgap);
      bit p0, p1, p2;
      int gap;
      tick_t tk;
      p0 = 0; p1 = 0; p2 = 0; gap = 0;
      while (tq.size() != 0 || p1 || p2) begin
         @(posedge clk); #1;
         p0 = p1; p1 = p2; p2 = 0;
         if (gap > 0) gap--;
         else if (tq.size() != 0) begin
            tk = tq.pop_front();
            p2 = 1;
            vga_h_sync = ~tk.hs_low;
            vga_v_sync = ~tk.vs_low;
            gap = int'($urandom_range(maxgap - 1, 0));
         end
         pixel_en = p0;
      end
      @(posedge clk); #1;
      pixel_en = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   logic tick_e = 1'b0, rst_e = 1'b0;
   obs_t last_exp = '0, mon_act, mon_exp;

   always @(posedge clk) begin
      tick_e <= pixel_en;
      rst_e  <= rst;
   end

   always @(negedge clk) begin
      mon_act = {CounterX, CounterY, line_len, frame_lines, inDisplayArea, locked, sync_err};
      if (rst_e) begin
         last_exp = '0;
         check_obs("reset_state", mon_act, last_exp);
      end else if (tick_e) begin
         if (eq.size() == 0) begin
            checks++;
            $display("FAIL tick_underflow t=%0t got unexpected tick want none", $time);
         end else begin
            mon_exp = eq.pop_front();
            check_obs("tick", mon_act, mon_exp);
            last_exp = mon_exp;
            last_exp.err = 1'b0;
         end
      end else begin
         check_obs("hold", mon_act, last_exp);
      end
   end

   initial begin
      rst = 1'b1; pixel_en = 1'b0; vga_h_sync = 1'b1; vga_v_sync = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Clean timing, tick every clk: lock at second frame start
      repeat (5) gen_tick(1'b0, 1'b0);
      repeat (3) gen_frame(LINE, LINES, -1);
      run_seg(1);
      check_val("c1_locked", locked, 1);
      check_val("c1_line_len", line_len, LINE);
      check_val("c1_frame_lines", frame_lines, LINES);

      // One short line drops lock; relock after a clean frame
      gen_frame(LINE, LINES, 5);
      repeat (2) gen_frame(LINE, LINES, -1);
      run_seg(1);
      check_val("c3_relocked", locked, 1);

      // hsync stuck high: counter saturates, timeout drops lock
      repeat (140) gen_tick(1'b0, 1'b0);
      run_seg(1);
      check_val("c4_x_saturated", CounterX, MAXV);
      check_val("c4_unlocked", locked, 0);
      repeat (3) gen_frame(LINE, LINES, -1);
      run_seg(1);
      check_val("c4_relocked", locked, 1);

      // Reset mid-frame while locked
      gen_line(LINE, 1'b1);
      repeat (9) gen_line(LINE, 1'b0);
      gen_tick(1'b1, 1'b0);
      repeat (19) gen_tick(1'b0, 1'b0);
      run_seg(1);
      check_val("c5_pre_x", CounterX, 19);
      check_val("c5_pre_y", CounterY, 10);
      pulse_reset();
      check_val("c5_post_locked", locked, 0);
      check_val("c5_post_x", CounterX, 0);
      repeat (3) gen_frame(LINE, LINES, -1);
      run_seg(1);
      check_val("c5_relocked", locked, 1);

      // Random tick gaps give the same results as steady ticks
      pulse_reset();
      repeat (5) gen_tick(1'b0, 1'b0);
      repeat (2) gen_frame(LINE, LINES, -1);
      gen_line(LINE, 1'b1);
      run_seg(20);
      check_val("c6_locked", locked, 1);
      check_val("c6_line_len", line_len, LINE);
      check_val("c6_frame_lines", frame_lines, LINES);

      repeat (3) @(posedge clk);
      #1 check_val("scoreboard_drained", eq.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
